mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port `in_valid`, input, 1 bit: the EX/M entry is valid this cycle.
REQ-004 SHALL have port `in_rd_addr`, input, 5 bits: destination register.
REQ-005 SHALL have port `in_rd`, input, 32 bits: ALU result; this is the byte address for memory ops.
REQ-006 SHALL have ports `in_wb_en`, `in_wb_from_mem`, `in_mem_write`, input, 1 bit each: writeback enable, load, store.
REQ-007 SHALL have port `in_funct3`, input, 3 bits: access size/sign, per RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-008 SHALL have port `in_store_data`, input, 32 bits: rs2 value for stores.
REQ-009 SHALL have port `stall`, output, 1 bit: holds the EX/M register and all upstream stages.
REQ-010 SHALL have memory request ports: `mem_req_valid` output 1; `mem_req_ready` input 1; `mem_addr` output 32 (word-aligned, [1:0]=0); `mem_we` output 1; `mem_wdata` output 32; `mem_wstrb` output 4.
REQ-011 SHALL have memory response ports: `mem_rsp_valid` input 1; `mem_rsp_data` input 32 (full aligned word).
REQ-012 SHALL have writeback outputs: `wb_rd_addr` 5, `wb_data` 32, `wb_en` 1, all registered.
REQ-013 SHALL have port `misaligned`, output, 1 bit: registered one-cycle fault pulse.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-015 SHALL drive `stall` = 1 whenever state != IDLE, combinationally.
REQ-016 In IDLE, when in_valid=1 and the entry is neither load nor store: wb_* SHALL take in_rd_addr/in_rd/in_wb_en at the next edge (latency 1).
REQ-017 In IDLE, when in_valid=1 and the entry is an aligned load/store: SHALL latch the entry, go to REQ, and drive wb_en=0 at the next edge.
REQ-018 When in_mem_write=1 and in_wb_from_mem=1 together: SHALL treat the entry as a store with no writeback.
REQ-019 In REQ: mem_req_valid=1; mem_addr, mem_we, mem_wdata, mem_wstrb SHALL stay stable until the mem_req_ready=1 edge; then go to WAIT.
REQ-020 In WAIT: hold until mem_rsp_valid=1, then return to IDLE at that edge.
REQ-021 On that edge, a load SHALL write wb_rd_addr, extracted wb_data, and wb_en=latched wb_en; a store SHALL drive wb_en=0.
REQ-022 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-023 Load extraction, lane = addr[1:0]: LB sign-extends the byte, LBU zero-extends it; LH/LHU select the half by addr[1]; LW takes the full word.
REQ-024 Store encoding: SB strb = 4'b0001 << addr[1:0], data = byte replicated x4; SH strb = 4'b0011 << addr[1:0], data = half x2; SW strb = 4'b1111.
REQ-025 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): SHALL issue no request, stay in IDLE, pulse misaligned=1 for one cycle, and drive wb_en=0.
REQ-026 wb_en SHALL be forced to 0 when the destination is x0.
REQ-027 When in_valid=0 in IDLE: wb_en=0 at the next edge.

Reset
REQ-028 rst=0 at an edge SHALL set state=IDLE, wb_rd_addr=0, wb_data=0, wb_en=0, misaligned=0, mem_req_valid=0, and clear the latched entry.
REQ-029 Reset during REQ/WAIT SHALL abandon the access; a later response in IDLE SHALL be ignored; stall=0 from the cycle after reset.

Verification
REQ-030 ALU op rd=5, in_rd=0x1234 -> next cycle wb_en=1, wb_rd_addr=5, wb_data=0x1234, stall=0.
REQ-031 LB at 0x103, ready immediate, rsp 0x80FF_0000 one cycle later -> mem_addr=0x100, stall=1 for 2 cycles, wb_data=0xFFFF_FF80.
REQ-032 SH at 0x202 with data 0x0000_ABCD, ready delayed 3 cycles -> mem_wstrb=4'b1100, mem_wdata=0xABCD_ABCD, request stable throughout, wb_en=0.
REQ-033 LW at 0x0000_0006 -> misaligned pulse, no mem_req_valid, wb_en=0.
REQ-034 rst=0 while in WAIT, then rsp_valid=1 -> wb_en stays 0, state IDLE, stall=0.
REQ-035 Load to x0 with rsp 0xDEAD_BEEF -> wb_en=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: passes ALU results straight to writeback and
// runs loads/stores through a valid/ready request channel with a separate response beat.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_rd,
  input  logic        in_wb_en,
  input  logic        in_wb_from_mem,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Latched memory entry; held unchanged for the whole REQ/WAIT lifetime.
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        ld_wb_en_q, ld_wb_en_d;
  logic [2:0]  funct3_q, funct3_d;

  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_en_q, wb_en_d;
  logic        misaligned_q, misaligned_d;

  // Incoming entry decode
  logic        is_store;
  logic        is_load;
  logic        is_mem;
  logic        addr_misaligned;
  logic        rd_nonzero;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;

  // Response extraction
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  logic [31:0] ld_data;

  // A store with the load flag also set is still just a store.
  assign is_store   = in_mem_write;
  assign is_load    = in_wb_from_mem & ~in_mem_write;
  assign is_mem     = is_store | is_load;
  assign rd_nonzero = |in_rd_addr;

  always_comb begin
    addr_misaligned = 1'b0;
    case (in_funct3[1:0])
      2'b00:   addr_misaligned = 1'b0;
      2'b01:   addr_misaligned = in_rd[0];
      default: addr_misaligned = |in_rd[1:0];
    endcase
  end

  always_comb begin
    st_wdata = in_store_data;
    st_strb  = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_store_data[7:0]}};
        st_strb  = 4'b0001 << in_rd[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_store_data[15:0]}};
        st_strb  = 4'b0011 << in_rd[1:0];
      end
      default: begin
        st_wdata = in_store_data;
        st_strb  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rsp_data[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte = mem_rsp_data[7:0];
      2'b01: ld_byte = mem_rsp_data[15:8];
      2'b10: ld_byte = mem_rsp_data[23:16];
      2'b11: ld_byte = mem_rsp_data[31:24];
      default: ld_byte = mem_rsp_data[7:0];
    endcase
  end

  assign ld_half   = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
  assign ld_signed = ~funct3_q[2];

  always_comb begin
    ld_data = mem_rsp_data;
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = mem_rsp_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rd_addr_d    = rd_addr_q;
    ld_wb_en_d   = ld_wb_en_q;
    funct3_d     = funct3_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_data_d    = wb_data_q;
    wb_en_d      = 1'b0;
    misaligned_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_rd_addr_d = in_rd_addr;
            wb_data_d    = in_rd;
            wb_en_d      = in_wb_en & rd_nonzero;
          end else if (addr_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            // Upstream advances on this same edge, so the entry must be captured here.
            addr_d     = in_rd;
            we_d       = is_store;
            wdata_d    = is_store ? st_wdata : 32'd0;
            wstrb_d    = is_store ? st_strb : 4'b0000;
            rd_addr_d  = in_rd_addr;
            ld_wb_en_d = is_load & in_wb_en & rd_nonzero;
            funct3_d   = in_funct3;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_rd_addr_d = rd_addr_q;
            wb_data_d    = ld_data;
            wb_en_d      = ld_wb_en_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'b0000;
      rd_addr_q    <= 5'd0;
      ld_wb_en_q   <= 1'b0;
      funct3_q     <= 3'd0;
      wb_rd_addr_q <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_en_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rd_addr_q    <= rd_addr_d;
      ld_wb_en_q   <= ld_wb_en_d;
      funct3_q     <= funct3_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_data_q    <= wb_data_d;
      wb_en_q      <= wb_en_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign stall         = (state_q != IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_data       = wb_data_q;
  assign wb_en         = wb_en_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an arithmetic model of
// RISC-V load/store lane rules and the request/response handshake timing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd;
  logic        in_wb_en;
  logic        in_wb_from_mem;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_store_data;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_rd_addr    (in_rd_addr),
    .in_rd         (in_rd),
    .in_wb_en      (in_wb_en),
    .in_wb_from_mem(in_wb_from_mem),
    .in_mem_write  (in_mem_write),
    .in_funct3     (in_funct3),
    .in_store_data (in_store_data),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .wb_en         (wb_en),
    .misaligned    (misaligned)
  );

  // Reference model: access size in bytes and lane arithmetic
  function automatic int ref_size(input logic [2:0] f3);
    int code;
    code = int'(f3) % 4;
    return 1 << code;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % ref_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
    int mask;
    mask = (1 << ref_size(f3)) - 1;
    return 4'(mask << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = ref_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned lane;
    logic [31:0] v;
    logic        is_unsigned;
    lane        = addr % 4;
    is_unsigned = (f3 >= 3'd4);
    v           = word;
    if (ref_size(f3) == 1) begin
      v = (word >> (8 * lane)) & 32'hFF;
      if (!is_unsigned && v >= 32'd128) v = v - 32'd256;
    end else if (ref_size(f3) == 2) begin
      v = (word >> (16 * (lane / 2))) & 32'hFFFF;
      if (!is_unsigned && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_rd_addr     = 5'd0;
    in_rd          = 32'd0;
    in_wb_en       = 1'b0;
    in_wb_from_mem = 1'b0;
    in_mem_write   = 1'b0;
    in_funct3      = 3'd0;
    in_store_data  = 32'd0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
  endtask

  // One pipeline entry from presentation through writeback, checked against the model.
  task automatic run_op(input string name, input logic v, input logic [4:0] rd,
                        input logic [31:0] addr, input logic wbe, input logic ld,
                        input logic st, input logic [2:0] f3, input logic [31:0] sdata,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rsp_word,
                        input logic spur);
    logic        is_store, is_load, is_mem, mis, exp_en;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_strb;
    int          n_stall;
    is_store  = st;
    is_load   = ld && !st;
    is_mem    = is_store || is_load;
    mis       = ref_misaligned(f3, addr);
    exp_addr  = addr & ~32'd3;
    exp_wdata = ref_wdata(f3, sdata);
    exp_strb  = ref_strb(f3, addr);
    exp_ld    = ref_load(f3, addr, rsp_word);

    in_valid = v; in_rd_addr = rd; in_rd = addr; in_wb_en = wbe;
    in_wb_from_mem = ld; in_mem_write = st; in_funct3 = f3; in_store_data = sdata;
    mem_rsp_valid = spur; mem_rsp_data = rsp_word ^ 32'h5A5A_5A5A;
    step();
    in_valid = 1'b0; mem_rsp_valid = 1'b0;

    if (!v) begin
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL %s:wb_en got %0b exp 0", name, wb_en); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s:stall got %0b exp 0", name, stall); end
      $display("txn %s bubble wb_en=%0b", name, wb_en);
    end else if (!is_mem) begin
      exp_en = wbe && (rd != 0);
      checks++; if (wb_en !== exp_en) begin errors++; $display("FAIL %s:wb_en got %0b exp %0b", name, wb_en, exp_en); end
      checks++; if (wb_rd_addr !== rd) begin errors++; $display("FAIL %s:wb_rd_addr got %0d exp %0d", name, wb_rd_addr, rd); end
      checks++; if (wb_data !== addr) begin errors++; $display("FAIL %s:wb_data got %08h exp %08h", name, wb_data, addr); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s:stall got %0b exp 0", name, stall); end
      $display("txn %s alu rd=%0d data=%08h wb_en=%0b", name, rd, wb_data, wb_en);
    end else if (mis) begin
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL %s:misaligned got %0b exp 1", name, misaligned); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL %s:wb_en got %0b exp 0", name, wb_en); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s:mem_req_valid got %0b exp 0", name, mem_req_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s:stall got %0b exp 0", name, stall); end
      step();
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL %s:misaligned_pulse got %0b exp 0", name, misaligned); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s:mem_req_valid_late got %0b exp 0", name, mem_req_valid); end
      $display("txn %s misaligned f3=%0d addr=%08h", name, f3, addr);
    end else begin
      n_stall = 0;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL %s:wb_en_issue got %0b exp 0", name, wb_en); end
      for (int i = 0; i <= rdy_dly; i++) begin
        if (stall === 1'b1) n_stall++;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s:mem_req_valid got %0b exp 1 cyc %0d", name, mem_req_valid, i); end
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL %s:mem_addr got %08h exp %08h cyc %0d", name, mem_addr, exp_addr, i); end
        checks++; if (mem_we !== is_store) begin errors++; $display("FAIL %s:mem_we got %0b exp %0b cyc %0d", name, mem_we, is_store, i); end
        if (is_store) begin
          checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL %s:mem_wdata got %08h exp %08h cyc %0d", name, mem_wdata, exp_wdata, i); end
          checks++; if (mem_wstrb !== exp_strb) begin errors++; $display("FAIL %s:mem_wstrb got %b exp %b cyc %0d", name, mem_wstrb, exp_strb, i); end
        end
        mem_req_ready = (i == rdy_dly);
        mem_rsp_valid = spur;
        step();
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
        if (stall === 1'b1) n_stall++;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s:mem_req_valid_wait got %0b exp 0", name, mem_req_valid); end
        mem_rsp_valid = (i == rsp_dly);
        mem_rsp_data  = (i == rsp_dly) ? rsp_word : $urandom;
        step();
      end
      mem_rsp_valid = 1'b0;
      exp_en = is_load && wbe && (rd != 0);
      checks++; if (n_stall != rdy_dly + rsp_dly + 2) begin errors++; $display("FAIL %s:stall_cycles got %0d exp %0d", name, n_stall, rdy_dly + rsp_dly + 2); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s:stall_done got %0b exp 0", name, stall); end
      checks++; if (wb_en !== exp_en) begin errors++; $display("FAIL %s:wb_en got %0b exp %0b", name, wb_en, exp_en); end
      if (is_load) begin
        checks++; if (wb_rd_addr !== rd) begin errors++; $display("FAIL %s:wb_rd_addr got %0d exp %0d", name, wb_rd_addr, rd); end
        checks++; if (wb_data !== exp_ld) begin errors++; $display("FAIL %s:wb_data got %08h exp %08h", name, wb_data, exp_ld); end
      end
      $display("txn %s %s f3=%0d addr=%08h rd=%0d rdy=%0d rsp=%0d wb_en=%0b wb_data=%08h",
               name, is_store ? "store" : "load", f3, addr, rd, rdy_dly, rsp_dly, wb_en, wb_data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    in_valid = 1'b1; in_rd_addr = 5'd4; in_rd = 32'hCAFE; in_wb_en = 1'b1;
    step();
    step();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset:wb_en got %0b exp 0", wb_en); end
    checks++; if (wb_rd_addr !== 5'd0) begin errors++; $display("FAIL reset:wb_rd_addr got %0d exp 0", wb_rd_addr); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset:wb_data got %08h exp 0", wb_data); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset:misaligned got %0b exp 0", misaligned); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset:mem_req_valid got %0b exp 0", mem_req_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset:stall got %0b exp 0", stall); end
    idle_inputs();
    rst = 1'b1;
    $display("txn reset wb_en=%0b stall=%0b", wb_en, stall);
  endtask

  task automatic test_alu();
    run_op("alu_rd5", 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 0, 0, 32'd0, 1'b1);
    run_op("alu_x0", 1'b1, 5'd0, 32'h7777, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run_op("bubble", 1'b0, 5'd6, 32'h1, 1'b1, 1'b1, 1'b0, 3'd2, 32'd0, 0, 0, 32'd0, 1'b0);
  endtask

  task automatic test_lb();
    run_op("lb_103", 1'b1, 5'd7, 32'h103, 1'b1, 1'b1, 1'b0, 3'b000, 32'd0, 0, 0, 32'h80FF_0000, 1'b0);
    checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_103:wb_data_const got %08h exp ffffff80", wb_data); end
  endtask

  task automatic test_sh();
    run_op("sh_202", 1'b1, 5'd3, 32'h202, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_ABCD, 3, 1, 32'd0, 1'b1);
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL sh_202:wb_en_const got %0b exp 0", wb_en); end
    run_op("st_ld_both", 1'b1, 5'd9, 32'h300, 1'b1, 1'b1, 1'b1, 3'b010, 32'h1122_3344, 0, 0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_misaligned();
    run_op("lw_006", 1'b1, 5'd8, 32'h6, 1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 0, 0, 32'd0, 1'b0);
    run_op("lh_odd", 1'b1, 5'd8, 32'h41, 1'b1, 1'b1, 1'b0, 3'b001, 32'd0, 0, 0, 32'd0, 1'b0);
    run_op("sw_002", 1'b1, 5'd8, 32'h42, 1'b0, 1'b0, 1'b1, 3'b010, 32'h55, 0, 0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; in_rd_addr = 5'd9; in_rd = 32'h40; in_wb_en = 1'b1;
    in_wb_from_mem = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b010;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_wait:stall_wait got %0b exp 1", stall); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait:stall_after_rst got %0b exp 0", stall); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1357_9BDF;
    step();
    mem_rsp_valid = 1'b0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wait:wb_en got %0b exp 0", wb_en); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait:stall got %0b exp 0", stall); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_wait:mem_req_valid got %0b exp 0", mem_req_valid); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rst_wait:wb_data got %08h exp 0", wb_data); end
    $display("txn rst_wait wb_en=%0b stall=%0b", wb_en, stall);
    run_op("after_rst", 1'b1, 5'd2, 32'hABC, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 0, 0, 32'd0, 1'b0);
  endtask

  task automatic test_load_x0();
    run_op("lw_x0", 1'b1, 5'd0, 32'h80, 1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 1, 2, 32'hDEAD_BEEF, 1'b0);
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL lw_x0:wb_en_const got %0b exp 0", wb_en); end
  endtask

  task automatic test_random();
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    int          kind;
    string       nm;
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      addr = $urandom;
      nm   = $sformatf("rnd%0d", t);
      if (kind <= 5) f3 = ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) addr = addr & ~(32'(ref_size(f3)) - 32'd1);
      if (kind == 0)
        run_op(nm, 1'b0, rd, addr, 1'($urandom), 1'($urandom), 1'($urandom), f3, $urandom, 0, 0, 32'd0, 1'($urandom));
      else if (kind <= 2)
        run_op(nm, 1'b1, rd, addr, 1'($urandom), 1'b0, 1'b0, f3, $urandom, 0, 0, 32'd0, 1'($urandom));
      else if (kind <= 5)
        run_op(nm, 1'b1, rd, addr, 1'($urandom), 1'b1, 1'b0, f3, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
      else
        run_op(nm, 1'b1, rd, addr, 1'($urandom), 1'($urandom), 1'b1, f3, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misaligned();
    test_reset_in_wait();
    test_load_x0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
